// File: rtl/pixel_word_packer.sv
// Packs a strobed 8-bit pixel stream into 32-bit words with raster tracking,
// a show-ahead word FIFO, end-of-frame marking and sticky overflow detection.
module pixel_word_packer #(
    parameter int unsigned IMG_W      = 256,
    parameter int unsigned IMG_H      = 256,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_strb,
    input  logic [7:0]                    i_data,
    output logic                          o_valid,
    input  logic                          o_ready,
    output logic [31:0]                   o_data,
    output logic                          o_last,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic [15:0]                   o_frame_cnt,
    output logic                          o_overflow,
    input  logic                          clr_err
);

    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned ENT_W = 33;

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [23:0]      r_hold;
    logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             r_valid;
    logic [15:0]      r_frame_cnt;
    logic             r_overflow;

    logic [1:0]       w_lane;
    logic             w_col_last;
    logic             w_row_last;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_push_acc;
    logic             w_drop;
    logic [ENT_W-1:0] w_word;
    logic [ENT_W-1:0] w_head;
    logic [LVL_W-1:0] w_level_nxt;

    // Push/pop decisions; o_ready only reaches registers, never o_valid/o_data.
    always_comb begin
        w_lane      = r_col[1:0];
        w_col_last  = (r_col == COL_W'(IMG_W - 1));
        w_row_last  = (r_row == ROW_W'(IMG_H - 1));
        w_push      = i_strb & (w_lane == 2'd3);
        w_pop       = r_valid & o_ready;
        w_full      = (r_level == LVL_W'(FIFO_DEPTH));
        w_push_acc  = w_push & (~w_full | w_pop);
        w_drop      = w_push & ~w_push_acc;
        w_word      = {w_row_last & w_col_last, i_data, r_hold};
        w_head      = r_mem[r_rd_ptr];
        w_level_nxt = r_level + LVL_W'(w_push_acc) - LVL_W'(w_pop);
    end

    // Raster position; advances on every strobe even if the word is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_strb) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // Holding register for lanes 0..2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= '0;
        end else if (i_strb) begin
            case (w_lane)
                2'd0:    r_hold[7:0]   <= i_data;
                2'd1:    r_hold[15:8]  <= i_data;
                2'd2:    r_hold[23:16] <= i_data;
                default: r_hold        <= r_hold;
            endcase
        end
    end

    // Word storage: {last, word} per entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push_acc) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    // Pointers, occupancy and registered valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_level <= w_level_nxt;
            r_valid <= (w_level_nxt != '0);
        end
    end

    // Frame counter and sticky overflow; a new drop beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_pop && w_head[32]) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign o_valid     = r_valid;
    assign o_data      = w_head[31:0];
    assign o_last      = w_head[32];
    assign o_level     = r_level;
    assign o_frame_cnt = r_frame_cnt;
    assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_pixel_word_packer.sv
// Bench for pixel_word_packer: directed scenarios with random pixels, checked
// against a queue-based model of pixel numbering, word packing and the FIFO.
module tb_pixel_word_packer;

    localparam int W = 8;
    localparam int H = 2;
    localparam int D = 8;
    localparam int FRAME = W * H;

    logic        clk;
    logic        rst_n;
    logic        i_strb;
    logic [7:0]  i_data;
    logic        o_valid;
    logic        o_ready;
    logic [31:0] o_data;
    logic        o_last;
    logic [3:0]  o_level;
    logic [15:0] o_frame_cnt;
    logic        o_overflow;
    logic        clr_err;

    pixel_word_packer #(.IMG_W(W), .IMG_H(H), .FIFO_DEPTH(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_strb      (i_strb),
        .i_data      (i_data),
        .o_valid     (o_valid),
        .o_ready     (o_ready),
        .o_data      (o_data),
        .o_last      (o_last),
        .o_level     (o_level),
        .o_frame_cnt (o_frame_cnt),
        .o_overflow  (o_overflow),
        .clr_err     (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [32:0] mq[$];
    logic [32:0] got[$];
    logic [7:0]  dv[$];
    logic [7:0]  mb[4];
    int          pc;
    int          exp_fc;
    logic        exp_ovf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected word k of the current pixel list: index-within-frame decides last.
    function automatic logic [32:0] expw(input int k);
        logic l;
        l = (((4 * k + 3) % FRAME) == FRAME - 1);
        return {l, dv[4*k+3], dv[4*k+2], dv[4*k+1], dv[4*k]};
    endfunction

    task automatic do_reset();
        rst_n   = 1'b0;
        i_strb  = 1'b0;
        i_data  = 8'h00;
        o_ready = 1'b0;
        clr_err = 1'b0;
        #2;
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_data", 64'(o_data), 64'd0);
        chk("rst_last", 64'(o_last), 64'd0);
        chk("rst_level", 64'(o_level), 64'd0);
        chk("rst_fc", 64'(o_frame_cnt), 64'd0);
        chk("rst_ovf", 64'(o_overflow), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mq.delete();
        got.delete();
        dv.delete();
        pc      = 0;
        exp_fc  = 0;
        exp_ovf = 1'b0;
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic step(input logic strb, input logic [7:0] d, input logic rdy, input logic clr);
        logic        pop;
        logic        have;
        logic        acc;
        logic        stall;
        logic [31:0] pdata;
        logic        plast;
        logic [32:0] w;
        i_strb  = strb;
        i_data  = strb ? d : 8'hxx;
        o_ready = rdy;
        clr_err = clr;
        have    = 1'b0;
        w       = '0;
        pop     = (mq.size() != 0) && rdy;
        if (strb) begin
            dv.push_back(d);
            mb[pc % 4] = d;
            if (pc % 4 == 3) begin
                have = 1'b1;
                w    = {(pc == FRAME - 1), mb[3], mb[2], mb[1], mb[0]};
            end
            pc = (pc + 1) % FRAME;
        end
        acc = have && ((mq.size() < D) || pop);
        if (pop) begin
            if (mq[0][32]) exp_fc = (exp_fc + 1) % 65536;
            void'(mq.pop_front());
        end
        if (acc) mq.push_back(w);
        if (have && !acc) exp_ovf = 1'b1;
        else if (clr) exp_ovf = 1'b0;
        stall = o_valid && !rdy;
        pdata = o_data;
        plast = o_last;
        if (o_valid && rdy) got.push_back({o_last, o_data});
        @(posedge clk);
        #1;
        chk("valid", 64'(o_valid), 64'(mq.size() != 0));
        chk("level", 64'(o_level), 64'(mq.size()));
        chk("frame_cnt", 64'(o_frame_cnt), 64'(exp_fc));
        chk("overflow", 64'(o_overflow), 64'(exp_ovf));
        if (mq.size() != 0) begin
            chk("head_word", 64'({o_last, o_data}), 64'(mq[0]));
        end
        if (stall) begin
            chk("stall_data", 64'(o_data), 64'(pdata));
            chk("stall_last", 64'(o_last), 64'(plast));
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        i_strb  = 1'b0;
        i_data  = 8'h00;
        o_ready = 1'b0;
        clr_err = 1'b0;

        // Basic packing and first-word latency
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 8'(i), 1'b1, 1'b0);
            if (i == 3) chk("t1_not_yet", 64'(o_valid), 64'd0);
            if (i == 4 || i == 8) chk("t1_latency", 64'(o_valid), 64'd1);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t1_count", 64'(got.size()), 64'd2);
        if (got.size() == 2) begin
            chk("t1_w0", 64'(got[0]), 64'({1'b0, 32'h04030201}));
            chk("t1_w1", 64'(got[1]), 64'({1'b0, 32'h08070605}));
        end

        // Frame end with sparse strobes, two frames
        do_reset();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < FRAME; i++) begin
                step(1'b1, 8'($urandom), 1'b1, 1'b0);
                for (int j = 0; j < 7; j++) step(1'b0, 8'h00, 1'b1, 1'b0);
            end
        end
        chk("t2_count", 64'(got.size()), 64'd8);
        for (int k = 0; k < 8 && k < got.size(); k++) begin
            chk("t2_word", 64'(got[k]), 64'(expw(k)));
        end
        chk("t2_fc", 64'(o_frame_cnt), 64'd2);

        // Overflow: nine words into a stalled FIFO, drain, then clear
        do_reset();
        for (int i = 0; i < 36; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        chk("t3_level", 64'(o_level), 64'd8);
        chk("t3_ovf", 64'(o_overflow), 64'd1);
        for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t3_count", 64'(got.size()), 64'd8);
        for (int k = 0; k < 8 && k < got.size(); k++) begin
            chk("t3_word", 64'(got[k]), 64'(expw(k)));
        end
        chk("t3_ovf_held", 64'(o_overflow), 64'd1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        chk("t3_ovf_clr", 64'(o_overflow), 64'd0);

        // Full FIFO with push and pop on the same edge
        do_reset();
        for (int i = 0; i < 32; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        step(1'b1, 8'($urandom), 1'b1, 1'b0);
        chk("t4_level", 64'(o_level), 64'd8);
        chk("t4_ovf", 64'(o_overflow), 64'd0);
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t4_count", 64'(got.size()), 64'd9);
        if (got.size() == 9) chk("t4_new_8th", 64'(got[8]), 64'(expw(8)));

        // Reset mid-word discards the partial word
        do_reset();
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        step(1'b1, 8'hBB, 1'b1, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h11 + i), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t5_count", 64'(got.size()), 64'd1);
        if (got.size() != 0) chk("t5_w0", 64'(got[0]), 64'({1'b0, 32'h14131211}));
        chk("t5_fc", 64'(o_frame_cnt), 64'd0);

        // Random stalls over a 256-pixel stream
        do_reset();
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 8'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
        end
        for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t6_count", 64'(got.size()), 64'd64);
        for (int k = 0; k < 64 && k < got.size(); k++) begin
            chk("t6_word", 64'(got[k]), 64'(expw(k)));
        end
        chk("t6_ovf", 64'(o_overflow), 64'd0);
        chk("t6_fc", 64'(o_frame_cnt), 64'd16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pixel_word_packer.md
Name: pixel_word_packer

Overview:
Downstream stage of the smoothing filter. It consumes the filter's 8-bit pixel strobe stream (o_strb/o_data) and tracks raster position within the frame. It packs four consecutive pixels into 32-bit words and buffers them in a small show-ahead FIFO. It presents the words to a memory/bus writer over a valid/ready handshake, with end-of-frame marking and overflow detection.

Parameters:
IMG_W, 256, pixels per line; must be a multiple of 4
IMG_H, 256, lines per frame
FIFO_DEPTH, 8, word FIFO entries; power of 2, minimum 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
i_strb  input  1  pixel valid strobe from the filter; one pixel per high cycle, no backpressure
i_data  input  8  pixel value; sampled only when i_strb=1 (may be X otherwise)
o_valid  output  1  FIFO head word available
o_ready  input  1  consumer accepts the head word this cycle
o_data  output  32  packed word; first pixel in [7:0], fourth pixel in [31:24]
o_last  output  1  qualifies o_data as the final word of a frame
o_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
o_frame_cnt  output  16  count of completed frames, i.e. last words popped; wraps at 65535->0
o_overflow  output  1  sticky: a word was dropped because the FIFO was full
clr_err  input  1  synchronous clear of o_overflow

Behaviour:
- Reset (async, rst_n=0): FIFO empty; pack lane=0; col=0, row=0; o_valid=0, o_last=0, o_data=0, o_level=0, o_frame_cnt=0, o_overflow=0. A reset mid-frame or mid-word discards the partial word and restarts at pixel (0,0).
- Pixel position: col runs 0..IMG_W-1. At col=IMG_W-1, col wraps to 0 and row increments. At row=IMG_H-1 and col=IMG_W-1, both wrap to 0. Counters advance only on i_strb=1.
- Packing: lane = col[1:0]. On i_strb, i_data goes into byte lane. Lanes 0-2 go into the holding register. On lane 3, the word {i_data, hold[23:16], hold[15:8], hold[7:0]} plus a last bit (set iff row=IMG_H-1 and col=IMG_W-1) is pushed in the same edge.
- Latency: with the FIFO empty, o_valid rises the cycle after the edge that samples the 4th pixel strobe.
- FIFO is show-ahead. o_valid = (level != 0). o_data/o_last come from the head entry. pop = o_valid & o_ready.
- While o_valid=1 and o_ready=0, o_data and o_last stay stable.
- Push is accepted iff level < FIFO_DEPTH or pop occurs in the same cycle. When full, a simultaneous push and pop leaves level unchanged and sets no overflow.
- A push that is not accepted drops the word and sets o_overflow. Pixel counters still advance, so frame alignment is preserved.
- Push while empty: the word appears at the head the next cycle. There is no same-cycle bypass.
- o_frame_cnt increments on the edge where pop occurs with the head last bit = 1. If the last word was dropped, the count does not increment.
- clr_err=1 clears o_overflow next edge. A new overflow in the same cycle takes priority and leaves o_overflow set.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. level is updated as level + push_acc - pop.
- Implementation: counters, holding register, 33-bit x FIFO_DEPTH register array, pointer/level logic. No combinational path from o_ready to o_valid or o_data.

Test Plan:
1. Basic packing. o_ready=1; pixels 0x01..0x08 on consecutive strobes. Required: words 0x04030201 then 0x08070605; o_valid high 1 cycle after the 4th and after the 8th strobe; o_last=0.
2. Frame end. IMG_W=8, IMG_H=2; 16 pixels, strobed 1-of-8 cycles as the filter does; o_ready=1. Required: 4 words; o_last=1 only on the 4th; o_frame_cnt goes 0->1 on that pop. A second frame gives o_frame_cnt=2 and restarts lane/col/row at 0.
3. Overflow. o_ready=0; push 9 words. Required: o_level=8, o_overflow=1, 9th word absent. Then o_ready=1: 8 words drain in order. Then clr_err=1: o_overflow=0 next cycle.
4. Full with simultaneous push/pop. FIFO full; o_ready=1 on the cycle the 4th pixel of a new word is strobed. Required: o_level stays 8, o_overflow stays 0, new word emerges 8th.
5. Reset mid-word. Strobe 0xAA, 0xBB, then pulse rst_n low, then strobe 0x11..0x14. Required: first word out is 0x14131211; o_frame_cnt=0.
6. Stall stability. Random o_ready toggling during a 256-pixel stream. Required: all 64 words arrive in order; o_data/o_last never change while o_valid=1 and o_ready=0; o_overflow remains 0 at FIFO_DEPTH=8.
